util_stream_slave: RTL and testbench

// - Receive-side checker for AXI4-Stream packet traffic from util_stream_master.
// - Accepts packets and checks data against the master's start/inc/fix pattern. Also checks packet length and tdest.
// - Counts packets and errors, then reports done/pass. Used in loopback benches and on-board self-test.

---
 rtl/util_stream_pkg.sv | 30 +++
 rtl/util_lfsr.sv | 37 +++
 rtl/util_stream_slave.sv | 221 ++++++++++++++++++++++
 tb/tb_util_stream_slave.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/util_stream_pkg.sv
// ----------------------------------------------------------------------------
// util_stream_pkg
// Shared types and constants for the AXI4-Stream receive-side checker.
//   state_t     : checker run state (idle / running / finished)
//   PKT_NUM_INF : packet count meaning "receive forever"
//   CNT_SAT     : saturation value of the error counters
//   LFSR_SEED   : reload value of the backpressure LFSR
//   LFSR_TAPS   : Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1
//   sat_inc()   : saturating increment used by every error counter
// ----------------------------------------------------------------------------
package util_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] PKT_NUM_INF = 32'hFFFF_FFFF;
    localparam logic [31:0] CNT_SAT     = 32'hFFFF_FFFF;
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;

    // Error counters stick at their maximum rather than wrapping back to zero,
    // so a long run can never appear clean again.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == CNT_SAT) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/util_lfsr.sv
// ----------------------------------------------------------------------------
// util_lfsr
// Galois LFSR, right-shifting, used to generate pseudo-random backpressure.
// Parameters:
//   WIDTH : register width
//   TAPS  : feedback mask XORed in when the bit shifted out is 1
//   SEED  : value loaded on reset and on 'load'
// Ports:
//   clk    in  1      clock, rising edge
//   rstn   in  1      synchronous reset, active low
//   load   in  1      reload SEED (takes priority over enable)
//   enable in  1      advance one step
//   value  out WIDTH  current register contents
// ----------------------------------------------------------------------------
module util_lfsr #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             enable,
    output logic [WIDTH-1:0] value
);

    // The register is reloaded with a non-zero seed so it can never lock up
    // in the all-zero state; otherwise it steps once per enabled cycle.
    always_ff @(posedge clk) begin
        if (!rstn || load) begin
            value <= SEED;
        end else if (enable) begin
            value <= {1'b0, value[WIDTH-1:1]} ^ (value[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/util_stream_slave.sv
// ----------------------------------------------------------------------------
// util_stream_slave
// Receive-side checker for AXI4-Stream packets produced by util_stream_master.
// Checks every beat against the start/inc/fix data pattern, checks packet
// length and tdest, counts packets and errors and reports done/pass.
//
// Build option: define UTIL_STREAM_SLAVE_BACKPRESSURE_EN to gate tready with a
// 16-bit LFSR for pseudo-random backpressure. Without it tready is simply
// high for the whole run and no LFSR is built.
//
// Ports:
//   clk, rstn                 clock / synchronous active-low reset
//   exp_dest[4:0]             expected tdest
//   pkt_num[31:0]             packets per run, FFFFFFFF = unbounded
//   trans_len[31:0]           expected beats per packet, 0 = no length check
//   start_from, inc [DW-1:0]  data pattern start value and step
//   fix                       1 = every beat expected to equal start_from
//   check_start               level; rising edge while idle starts a run
//   check_busy/done/pass      run status
//   s_axis_*                  AXI4-Stream slave (tid unused)
//   pkt_cnt                   packets completed (wraps)
//   data/len/dest_err_cnt     saturating error counters
// ----------------------------------------------------------------------------
module util_stream_slave #(
    parameter int TBYTE_NUM = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [4:0]             exp_dest,
    input  logic [31:0]            pkt_num,
    input  logic [31:0]            trans_len,
    input  logic [TBYTE_NUM*8-1:0] start_from,
    input  logic [TBYTE_NUM*8-1:0] inc,
    input  logic                   fix,
    input  logic                   check_start,
    output logic                   check_busy,
    output logic                   check_done,
    output logic                   check_pass,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [TBYTE_NUM*8-1:0] s_axis_tdata,
    input  logic [TBYTE_NUM-1:0]   s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tid,
    input  logic [4:0]             s_axis_tdest,
    output logic [31:0]            pkt_cnt,
    output logic [31:0]            data_err_cnt,
    output logic [31:0]            len_err_cnt,
    output logic [31:0]            dest_err_cnt
);

    import util_stream_pkg::*;

    localparam int DW = TBYTE_NUM * 8;

    state_t          state, next_state;
    logic            start_d;
    logic            start_rise;
    logic            enter_run;
    logic            tready_q;
    logic            beat;
    logic            final_beat;

    logic [4:0]      exp_dest_q;
    logic [31:0]     pkt_num_q;
    logic [31:0]     trans_len_q;
    logic [DW-1:0]   start_q;
    logic [DW-1:0]   inc_q;
    logic            fix_q;
    logic [DW-1:0]   exp_data;
    logic [31:0]     beat_idx;
    logic            len_flagged;

    logic [31:0]     pkt_cnt_nxt;
    logic [31:0]     idx_plus1;
    logic            len_chk_en;
    logic            data_err;
    logic            dest_err;
    logic            len_err;

    logic            unused_tid;
    assign unused_tid = s_axis_tid;

    assign start_rise  = check_start && !start_d;
    assign enter_run   = (state == ST_IDLE) && start_rise;
    assign beat        = s_axis_tvalid && s_axis_tready;
    assign pkt_cnt_nxt = pkt_cnt + 32'd1;
    assign idx_plus1   = beat_idx + 32'd1;
    assign len_chk_en  = (trans_len_q != 32'd0);

    // The run ends on the tlast beat that brings pkt_cnt up to pkt_num; an
    // unbounded run only ends when check_start is dropped.
    assign final_beat = beat && s_axis_tlast && (pkt_num_q != PKT_NUM_INF)
                        && (pkt_cnt_nxt == pkt_num_q);

    assign data_err = (s_axis_tdata != exp_data) || (s_axis_tkeep != '1);
    assign dest_err = (beat_idx == 32'd0) && (s_axis_tdest != exp_dest_q);

    // A packet that reaches its expected length without tlast is flagged right
    // away; the flag then suppresses a second report when tlast arrives.
    assign len_err = !len_flagged && len_chk_en &&
                     (s_axis_tlast ? (idx_plus1 != trans_len_q)
                                   : (idx_plus1 == trans_len_q));

    // Registered copy of check_start so a run only starts on a fresh 0->1
    // edge, never on a level that was already high.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            start_d <= 1'b0;
        end else begin
            start_d <= check_start;
        end
    end

    // State register. tready is decoded from the next state so it is already
    // low on the cycle the state leaves RUN and no beat slips in afterwards.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            tready_q <= 1'b0;
        end else begin
            state    <= next_state;
            tready_q <= (next_state == ST_RUN);
        end
    end

    // Next-state logic. Dropping check_start always wins and returns to idle,
    // discarding any partially received packet.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start_rise)       next_state = ST_RUN;
            ST_RUN: begin
                if (!check_start)          next_state = ST_IDLE;
                else if (final_beat)       next_state = ST_DONE;
            end
            ST_DONE: if (!check_start)     next_state = ST_IDLE;
            default:                       next_state = ST_IDLE;
        endcase
    end

    // Status outputs are a plain decode of the current state.
    always_comb begin
        check_busy = (state == ST_RUN);
        check_done = (state == ST_DONE);
        check_pass = (state == ST_DONE) && (data_err_cnt == 32'd0)
                     && (len_err_cnt == 32'd0) && (dest_err_cnt == 32'd0);
    end

`ifdef UTIL_STREAM_SLAVE_BACKPRESSURE_EN
    logic [15:0] lfsr_value;
    logic [14:0] unused_lfsr;

    util_lfsr #(
        .WIDTH  (16),
        .TAPS   (LFSR_TAPS),
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rstn   (rstn),
        .load   (enter_run),
        .enable (state == ST_RUN),
        .value  (lfsr_value)
    );

    assign unused_lfsr   = lfsr_value[15:1];
    assign s_axis_tready = tready_q && lfsr_value[0];
`else
    assign s_axis_tready = tready_q;
`endif

    // Run configuration, expected data and all counters. Starting a run
    // latches the config and clears everything; afterwards each accepted beat
    // updates the pattern, the in-packet index and the counters one clock
    // after the handshake. Leaving RUN simply stops updates, so counts hold.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            exp_dest_q   <= '0;
            pkt_num_q    <= '0;
            trans_len_q  <= '0;
            start_q      <= '0;
            inc_q        <= '0;
            fix_q        <= 1'b0;
            exp_data     <= '0;
            beat_idx     <= '0;
            len_flagged  <= 1'b0;
            pkt_cnt      <= '0;
            data_err_cnt <= '0;
            len_err_cnt  <= '0;
            dest_err_cnt <= '0;
        end else if (enter_run) begin
            exp_dest_q   <= exp_dest;
            pkt_num_q    <= pkt_num;
            trans_len_q  <= trans_len;
            start_q      <= start_from;
            inc_q        <= inc;
            fix_q        <= fix;
            exp_data     <= start_from;
            beat_idx     <= '0;
            len_flagged  <= 1'b0;
            pkt_cnt      <= '0;
            data_err_cnt <= '0;
            len_err_cnt  <= '0;
            dest_err_cnt <= '0;
        end else if (beat) begin
            exp_data <= fix_q ? start_q : exp_data + inc_q;
            if (data_err) data_err_cnt <= sat_inc(data_err_cnt);
            if (dest_err) dest_err_cnt <= sat_inc(dest_err_cnt);
            if (len_err)  len_err_cnt  <= sat_inc(len_err_cnt);
            if (s_axis_tlast) begin
                pkt_cnt     <= pkt_cnt_nxt;
                beat_idx    <= '0;
                len_flagged <= 1'b0;
            end else begin
                beat_idx <= idx_plus1;
                if (len_err) len_flagged <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_util_stream_slave.sv
// ----------------------------------------------------------------------------
// tb_util_stream_slave
// Self-checking bench for util_stream_slave (TBYTE_NUM = 4). Acts as the
// stream master, keeps a reference model of the expected counters and
// compares DUT counters against a scoreboard one clock after each beat.
// ----------------------------------------------------------------------------
module tb_util_stream_slave;

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  exp_dest;
    logic [31:0] pkt_num;
    logic [31:0] trans_len;
    logic [31:0] start_from;
    logic [31:0] inc;
    logic        fix;
    logic        check_start;
    logic        check_busy;
    logic        check_done;
    logic        check_pass;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        s_axis_tid;
    logic [4:0]  s_axis_tdest;
    logic [31:0] pkt_cnt;
    logic [31:0] data_err_cnt;
    logic [31:0] len_err_cnt;
    logic [31:0] dest_err_cnt;

    typedef struct {
        logic [31:0] pkt;
        logic [31:0] derr;
        logic [31:0] lerr;
        logic [31:0] dserr;
    } sb_t;

    sb_t         sb_q[$];
    logic        beat_q = 1'b0;

    int          errors = 0;
    int          checks = 0;
    int          rdy_hi = 0;
    int          rdy_lo = 0;

    logic [31:0] m_exp, m_idx, m_pkt, m_derr, m_lerr, m_dserr;
    logic        m_flag;
    logic [31:0] tx_data;

    util_stream_slave #(.TBYTE_NUM(4)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .exp_dest      (exp_dest),
        .pkt_num       (pkt_num),
        .trans_len     (trans_len),
        .start_from    (start_from),
        .inc           (inc),
        .fix           (fix),
        .check_start   (check_start),
        .check_busy    (check_busy),
        .check_done    (check_done),
        .check_pass    (check_pass),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tid    (s_axis_tid),
        .s_axis_tdest  (s_axis_tdest),
        .pkt_cnt       (pkt_cnt),
        .data_err_cnt  (data_err_cnt),
        .len_err_cnt   (len_err_cnt),
        .dest_err_cnt  (dest_err_cnt)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Remember whether a handshake happened on the last rising edge so the
    // scoreboard entry can be popped at the following falling edge.
    always @(posedge clk) beat_q <= s_axis_tvalid && s_axis_tready;

    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge, then service the scoreboard and
    // sample tready while the DUT is running with data offered.
    task automatic tick();
        sb_t e;
        @(negedge clk);
        if (beat_q) begin
            if (sb_q.size() == 0) begin
                checkOutput("sb_unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("sb_pkt_cnt", pkt_cnt, e.pkt);
                checkOutput("sb_data_err", data_err_cnt, e.derr);
                checkOutput("sb_len_err", len_err_cnt, e.lerr);
                checkOutput("sb_dest_err", dest_err_cnt, e.dserr);
            end
        end
        if (check_busy && s_axis_tvalid) begin
            if (s_axis_tready) rdy_hi++;
            else rdy_lo++;
        end
    endtask

    // Offer one beat, wait (bounded) for tready, then update the reference
    // model and push the counter values expected after the beat.
    task automatic applyStimulus(input logic [31:0] data, input logic [3:0] keep,
                                 input logic last, input logic [4:0] dest);
        int  n = 0;
        sb_t e;
        s_axis_tdata  = data;
        s_axis_tkeep  = keep;
        s_axis_tlast  = last;
        s_axis_tdest  = dest;
        s_axis_tid    = 1'b0;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 200) begin
            tick();
            n++;
        end
        if (!s_axis_tready) begin
            checkOutput("tready_timeout", 32'd0, 32'd1);
            s_axis_tvalid = 1'b0;
            return;
        end
        if (data != m_exp || keep != 4'hF) m_derr = satInc(m_derr);
        m_exp = fix ? start_from : m_exp + inc;
        if (m_idx == 0 && dest != exp_dest) m_dserr = satInc(m_dserr);
        if (!m_flag && trans_len != 0) begin
            if (last && (m_idx + 1 != trans_len)) m_lerr = satInc(m_lerr);
            if (!last && (m_idx + 1 == trans_len)) begin
                m_lerr = satInc(m_lerr);
                m_flag = 1'b1;
            end
        end
        if (last) begin
            m_pkt  = m_pkt + 1;
            m_idx  = 0;
            m_flag = 1'b0;
        end else begin
            m_idx = m_idx + 1;
        end
        e.pkt = m_pkt; e.derr = m_derr; e.lerr = m_lerr; e.dserr = m_dserr;
        sb_q.push_back(e);
        tick();
    endtask

    // Send whole packets following the master's pattern; one beat may be
    // replaced by zero to inject a data error.
    task automatic sendPackets(input int n, input int beats, input logic [4:0] dest,
                               input int bad_pkt = -1, input int bad_beat = -1);
        for (int p = 0; p < n; p++) begin
            for (int b = 0; b < beats; b++) begin
                applyStimulus((p == bad_pkt && b == bad_beat) ? 32'd0 : tx_data,
                              4'hF, b == beats - 1, dest);
                tx_data = fix ? start_from : tx_data + inc;
            end
        end
    endtask

    task automatic startRun(input logic [31:0] pn, input logic [31:0] tl,
                            input logic [31:0] sf, input logic [31:0] ic,
                            input logic fx, input logic [4:0] dst);
        pkt_num = pn; trans_len = tl; start_from = sf; inc = ic; fix = fx;
        exp_dest = dst;
        check_start = 1'b1;
        tick();
        m_exp = sf; m_idx = 0; m_flag = 1'b0; m_pkt = 0;
        m_derr = 0; m_lerr = 0; m_dserr = 0; tx_data = sf;
        checkOutput("start_busy", {31'd0, check_busy}, 32'd1);
        checkOutput("start_pkt_cnt", pkt_cnt, 32'd0);
        checkOutput("start_data_err", data_err_cnt, 32'd0);
        checkOutput("start_len_err", len_err_cnt, 32'd0);
    endtask

    task automatic stopRun();
        s_axis_tvalid = 1'b0;
        check_start = 1'b0;
        tick();
        checkOutput("stop_busy", {31'd0, check_busy}, 32'd0);
        checkOutput("stop_done", {31'd0, check_done}, 32'd0);
        tick();
    endtask

    initial begin
        rstn = 1'b0; check_start = 1'b0; s_axis_tvalid = 1'b0;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        s_axis_tid = 1'b0; s_axis_tdest = '0;
        exp_dest = '0; pkt_num = '0; trans_len = '0;
        start_from = '0; inc = '0; fix = 1'b0;
        repeat (3) tick();
        checkOutput("rst_busy", {31'd0, check_busy}, 32'd0);
        checkOutput("rst_done", {31'd0, check_done}, 32'd0);
        checkOutput("rst_pass", {31'd0, check_pass}, 32'd0);
        checkOutput("rst_tready", {31'd0, s_axis_tready}, 32'd0);
        checkOutput("rst_pkt_cnt", pkt_cnt, 32'd0);
        checkOutput("rst_errs", data_err_cnt | len_err_cnt | dest_err_cnt, 32'd0);
        rstn = 1'b1;
        repeat (2) tick();

        $display("[TB] loopback 10 packets of 2 beats");
        startRun(32'd10, 32'd2, 32'd0, 32'd1, 1'b0, 5'd0);
        sendPackets(10, 2, 5'd0);
        s_axis_tvalid = 1'b0;
        checkOutput("t1_done", {31'd0, check_done}, 32'd1);
        checkOutput("t1_pass", {31'd0, check_pass}, 32'd1);
        checkOutput("t1_pkt_cnt", pkt_cnt, 32'd10);
        checkOutput("t1_tready_done", {31'd0, s_axis_tready}, 32'd0);
        stopRun();

        $display("[TB] fixed pattern with one corrupted beat");
        startRun(32'd3, 32'd4, 32'hA5A5_A5A5, 32'd7, 1'b1, 5'd0);
        sendPackets(3, 4, 5'd0, 1, 2);
        s_axis_tvalid = 1'b0;
        checkOutput("t2_data_err", data_err_cnt, 32'd1);
        checkOutput("t2_done", {31'd0, check_done}, 32'd1);
        checkOutput("t2_pass", {31'd0, check_pass}, 32'd0);
        stopRun();

        $display("[TB] tkeep error");
        startRun(32'd1, 32'd2, 32'h1000, 32'd4, 1'b0, 5'd0);
        applyStimulus(32'h1000, 4'h7, 1'b0, 5'd0);
        applyStimulus(32'h1004, 4'hF, 1'b1, 5'd0);
        s_axis_tvalid = 1'b0;
        checkOutput("t2b_data_err", data_err_cnt, 32'd1);
        checkOutput("t2b_pass", {31'd0, check_pass}, 32'd0);
        stopRun();

        $display("[TB] length errors");
        startRun(32'd2, 32'd4, 32'd0, 32'd1, 1'b0, 5'd0);
        sendPackets(1, 3, 5'd0);
        sendPackets(1, 5, 5'd0);
        s_axis_tvalid = 1'b0;
        checkOutput("t3_len_err", len_err_cnt, 32'd2);
        checkOutput("t3_pkt_cnt", pkt_cnt, 32'd2);
        checkOutput("t3_data_err", data_err_cnt, 32'd0);
        checkOutput("t3_done", {31'd0, check_done}, 32'd1);
        stopRun();

        $display("[TB] dest errors");
        startRun(32'd3, 32'd2, 32'd50, 32'd3, 1'b0, 5'd3);
        sendPackets(2, 2, 5'd3);
        sendPackets(1, 2, 5'd5);
        s_axis_tvalid = 1'b0;
        checkOutput("t4_dest_err", dest_err_cnt, 32'd1);
        checkOutput("t4_pass", {31'd0, check_pass}, 32'd0);
        stopRun();

        $display("[TB] unbounded run, abort mid-packet");
        startRun(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFF0, 32'd5, 1'b0, 5'd1);
        sendPackets(1000, 2, 5'd1);
        applyStimulus(tx_data, 4'hF, 1'b0, 5'd1);
        s_axis_tvalid = 1'b0;
        check_start = 1'b0;
        tick();
        checkOutput("t5_busy", {31'd0, check_busy}, 32'd0);
        checkOutput("t5_tready", {31'd0, s_axis_tready}, 32'd0);
        checkOutput("t5_pkt_cnt", pkt_cnt, 32'd1000);
        checkOutput("t5_done", {31'd0, check_done}, 32'd0);
        checkOutput("t5_data_err", data_err_cnt, 32'd0);
        repeat (2) tick();
        checkOutput("t5_pkt_hold", pkt_cnt, 32'd1000);

        $display("[TB] continuous valid, 20 packets");
        rdy_hi = 0; rdy_lo = 0;
        startRun(32'd20, 32'd4, 32'd9, 32'd2, 1'b0, 5'd2);
        sendPackets(20, 4, 5'd2);
        s_axis_tvalid = 1'b0;
        checkOutput("t6_done", {31'd0, check_done}, 32'd1);
        checkOutput("t6_pass", {31'd0, check_pass}, 32'd1);
        checkOutput("t6_pkt_cnt", pkt_cnt, 32'd20);
`ifdef UTIL_STREAM_SLAVE_BACKPRESSURE_EN
        checkOutput("t6_ready_some_high", {31'd0, rdy_hi != 0}, 32'd1);
        checkOutput("t6_ready_some_low", {31'd0, rdy_lo != 0}, 32'd1);
`else
        checkOutput("t6_ready_low_cycles", rdy_lo, 32'd0);
`endif
        stopRun();

        checkOutput("sb_leftover", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
